fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch PC after reset.
REQ-002 Parameter DEPTH, default 4: fetch-queue entries; power of two, at least 2.
REQ-003 clock_i  in  1: the single clock; all state updates on the rising edge.
REQ-004 reset_i  in  1: asynchronous, active-high reset.
REQ-005 imem_addr_o  out  10: byte address to the instruction memory; equals pc[9:0].
REQ-006 imem_stall_o  out  1: high holds the memory output register; low loads it at the edge.
REQ-007 imem_data_i  in  64: memory read data; byte at address a is in [63:56], a+7 is in [7:0].
REQ-008 redirect_i  in  1: flush the fetch path and restart at redirect_pc_i.
REQ-009 redirect_pc_i  in  32: target PC for a redirect.
REQ-010 valid_o  out  1: a fetch packet is presented to decode.
REQ-011 ready_i  in  1: decode accepts the packet; the packet transfers when valid_o and ready_i are both high.
REQ-012 pc_o  out  32: PC of inst0_o; the PC of inst1_o is pc_o+4.
REQ-013 inst0_o, inst1_o  out  32 each: the two instructions of the packet, in program order.

Function
REQ-014 Issue occurs in a cycle when (queue count + in-flight) < DEPTH and redirect_i is low; imem_stall_o = !issue.
REQ-015 On an issue edge, the in-flight flag and in-flight PC capture 1 and pc, and pc advances by 8; otherwise in-flight clears to 0.
REQ-016 The response is valid in the cycle after issue; it is pushed into the queue at the next edge.
REQ-017 Byte assembly is little-endian: inst0 = {d[39:32],d[47:40],d[55:48],d[63:56]} and inst1 = {d[7:0],d[15:8],d[23:16],d[31:24]}.
REQ-018 Address arithmetic is modulo 2^32 on pc; imem_addr_o wraps modulo 1024 with no special handling.
REQ-019 Any PC alignment is accepted; no alignment check is made and no exception is raised.
REQ-020 The queue is FIFO: a push and a pop in the same cycle leave the count unchanged, and a push at full cannot occur by construction.
REQ-021 valid_o = (count != 0); pc_o, inst0_o and inst1_o show the head entry and are 0 when the queue is empty.
REQ-022 Redirect edge: the queue empties, the in-flight flag and any response arriving that cycle are discarded, pc loads redirect_pc_i, and no issue happens.
REQ-023 A redirect takes priority over a simultaneous pop or push.
REQ-024 Fetch resumes with an issue in the cycle after a redirect, so the first new packet reaches valid_o 2 cycles after the redirect edge.
REQ-025 Throughput is one packet per cycle while ready_i is held high.

Reset
REQ-026 While reset_i is high: pc = RESET_PC, queue count = 0, read and write pointers = 0, in-flight = 0.
REQ-027 Output values while reset_i is high: valid_o = 0; pc_o, inst0_o, inst1_o = 0; imem_stall_o = 1; imem_addr_o = RESET_PC[9:0].
REQ-028 Reset asserted mid-operation discards all queued and in-flight packets immediately; there is no drain.

Structure
REQ-029 The core package holds XLEN = 32, IMEM_AW = 10, FETCH_W = 64 and the packet width (pc plus two instructions = 96 bits).
REQ-030 One sub-module, fetch_fifo, is used: a parameterized synchronous FIFO with a flush input, count output and asynchronous reset.

Verification
REQ-031 Release reset with RESET_PC = 0 and ready_i = 1 -> imem_addr_o = 0, 8, 16, ... on successive cycles, and packets arrive with pc_o = 0, 8, 16 and no gaps.
REQ-032 Memory bytes 0..7 = 13 05 10 00 93 05 20 00 -> inst0_o = 32'h00100513, inst1_o = 32'h00200593.
REQ-033 Hold ready_i = 0 for 10 cycles -> at most 4 packets are queued, imem_stall_o = 1 once full, and no packet is lost or duplicated after ready_i returns to 1.
REQ-034 redirect_i = 1 with redirect_pc_i = 32'h104 while the queue is full and a response is in flight -> valid_o = 0 the next cycle, then pc_o = 32'h104 with inst0_o taken from bytes 0x104..0x107.
REQ-035 pc = 32'h3F8 -> imem_addr_o sequence 0x3F8, 0x000, with pc_o continuing 32'h400.
REQ-036 Assert reset_i asynchronously mid-stream -> valid_o falls without waiting for a clock edge, and fetch restarts at RESET_PC after release.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared widths, the fetch packet layout and byte-order helper for the fetch path.
package fetch_unit_pkg;

    localparam int XLEN    = 32;
    localparam int IMEM_AW = 10;
    localparam int FETCH_W = 64;
    localparam int PKT_W   = 3 * XLEN;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst0;
        logic [XLEN-1:0] inst1;
    } fetch_pkt_t;

    // Memory delivers the lowest address in the top byte; instructions are little-endian.
    function automatic logic [XLEN-1:0] swap_word(input logic [XLEN-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush and occupancy count; holds fetched packets for decode.
module fetch_fifo #(
    parameter int WIDTH = 96,
    parameter int DEPTH = 4
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock_i) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Flush wins over any simultaneous push or pop.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues 8-byte reads, queues two-instruction packets for decode.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic               clock_i,
    input  logic               reset_i,
    output logic [IMEM_AW-1:0] imem_addr_o,
    output logic               imem_stall_o,
    input  logic [FETCH_W-1:0] imem_data_i,
    input  logic               redirect_i,
    input  logic [XLEN-1:0]    redirect_pc_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [XLEN-1:0]    pc_o,
    output logic [XLEN-1:0]    inst0_o,
    output logic [XLEN-1:0]    inst1_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupancy;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_pkt_t      resp_pkt;
    fetch_pkt_t      head_pkt;

    // In-flight reads reserve a queue slot so a push can never find the queue full.
    assign occupancy    = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue        = !reset_i && !redirect_i && (occupancy < (CW+1)'(DEPTH));
    assign imem_stall_o = !issue;
    assign imem_addr_o  = pc[IMEM_AW-1:0];

    assign push = inflight && !redirect_i;
    assign pop  = valid_o && ready_i && !redirect_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
        end else if (redirect_i) begin
            pc       <= redirect_pc_i;
            inflight <= 1'b0;
        end else if (issue) begin
            inflight    <= 1'b1;
            inflight_pc <= pc;
            pc          <= pc + 32'd8;
        end else begin
            inflight <= 1'b0;
        end
    end

    always_comb begin
        resp_pkt       = '0;
        resp_pkt.pc    = inflight_pc;
        resp_pkt.inst0 = swap_word(imem_data_i[63:32]);
        resp_pkt.inst1 = swap_word(imem_data_i[31:0]);
    end

    fetch_fifo #(
        .WIDTH (PKT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush   (redirect_i),
        .push    (push),
        .pop     (pop),
        .wr_data (resp_pkt),
        .rd_data (head_pkt),
        .count   (count)
    );

    assign valid_o = (count != '0);
    assign pc_o    = valid_o ? head_pkt.pc    : '0;
    assign inst0_o = valid_o ? head_pkt.inst0 : '0;
    assign inst1_o = valid_o ? head_pkt.inst1 : '0;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a byte-addressed instruction memory model.
module tb_fetch_unit;

    logic        clock_i = 1'b0;
    logic        reset_i;
    logic [9:0]  imem_addr_o;
    logic        imem_stall_o;
    logic [63:0] imem_data_i = '0;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] inst0_o;
    logic [31:0] inst1_o;

    logic [7:0]  mem [1024];
    logic [31:0] next_pc;
    int          vectors    = 0;
    int          miscompares = 0;

    fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .imem_addr_o   (imem_addr_o),
        .imem_stall_o  (imem_stall_o),
        .imem_data_i   (imem_data_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .valid_o       (valid_o),
        .ready_i       (ready_i),
        .pc_o          (pc_o),
        .inst0_o       (inst0_o),
        .inst1_o       (inst1_o)
    );

    always #5 clock_i = ~clock_i;

    // Memory output register: lowest address lands in the top byte.
    always @(posedge clock_i) begin
        if (!imem_stall_o) begin
            imem_data_i <= {mem[imem_addr_o],          mem[imem_addr_o + 10'd1],
                            mem[imem_addr_o + 10'd2],  mem[imem_addr_o + 10'd3],
                            mem[imem_addr_o + 10'd4],  mem[imem_addr_o + 10'd5],
                            mem[imem_addr_o + 10'd6],  mem[imem_addr_o + 10'd7]};
        end
    end

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        logic [9:0] a;
        a = addr[9:0];
        return {mem[a + 10'd3], mem[a + 10'd2], mem[a + 10'd1], mem[a]};
    endfunction

    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        ready_i = 1'b1;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        tick();
        tick();
        vectors++; if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b, expected 0", valid_o); end
        vectors++; if (pc_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_pc: got %h, expected 0", pc_o); end
        vectors++; if (inst0_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_inst0: got %h, expected 0", inst0_o); end
        vectors++; if (inst1_o !== 32'h0) begin miscompares++; $display("[TB] FAIL reset_inst1: got %h, expected 0", inst1_o); end
        vectors++; if (imem_stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_stall: got %b, expected 1", imem_stall_o); end
        vectors++; if (imem_addr_o !== 10'h0) begin miscompares++; $display("[TB] FAIL reset_addr: got %h, expected 0", imem_addr_o); end
    endtask

    task automatic test_startup();
        reset_i = 1'b0;
        next_pc = 32'h0;
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (imem_addr_o !== 10'(8 * k)) begin
                miscompares++; $display("[TB] FAIL start_addr[%0d]: got %h, expected %h", k, imem_addr_o, 10'(8 * k));
            end
            if (k < 2) begin
                vectors++;
                if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL start_valid_low[%0d]: got %b, expected 0", k, valid_o); end
            end else begin
                vectors++;
                if (valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL start_valid[%0d]: got %b, expected 1", k, valid_o); end
                vectors++;
                if (pc_o !== next_pc) begin miscompares++; $display("[TB] FAIL start_pc[%0d]: got %h, expected %h", k, pc_o, next_pc); end
                vectors++;
                if (inst0_o !== exp_word(next_pc)) begin miscompares++; $display("[TB] FAIL start_inst0[%0d]: got %h, expected %h", k, inst0_o, exp_word(next_pc)); end
                vectors++;
                if (inst1_o !== exp_word(next_pc + 32'd4)) begin miscompares++; $display("[TB] FAIL start_inst1[%0d]: got %h, expected %h", k, inst1_o, exp_word(next_pc + 32'd4)); end
                next_pc = next_pc + 32'd8;
            end
            if (k == 2) begin
                vectors++;
                if (inst0_o !== 32'h00100513) begin miscompares++; $display("[TB] FAIL byte_order_inst0: got %h, expected 00100513", inst0_o); end
                vectors++;
                if (inst1_o !== 32'h00200593) begin miscompares++; $display("[TB] FAIL byte_order_inst1: got %h, expected 00200593", inst1_o); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        ready_i = 1'b0;
        for (int j = 0; j < 10; j++) begin
            vectors++;
            if (valid_o !== 1'b1 || pc_o !== next_pc) begin
                miscompares++; $display("[TB] FAIL hold_head[%0d]: got valid=%b pc=%h, expected valid=1 pc=%h", j, valid_o, pc_o, next_pc);
            end
            if (j < 2) begin
                vectors++;
                if (imem_stall_o !== 1'b0) begin miscompares++; $display("[TB] FAIL hold_stall_low[%0d]: got %b, expected 0", j, imem_stall_o); end
            end else begin
                vectors++;
                if (imem_stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_stall_high[%0d]: got %b, expected 1", j, imem_stall_o); end
            end
            if (j == 9) begin
                vectors++;
                if (imem_addr_o !== 10'd80) begin miscompares++; $display("[TB] FAIL hold_addr: got %h, expected %h", imem_addr_o, 10'd80); end
            end
            tick();
        end
        ready_i = 1'b1;
        for (int j = 0; j < 12; j++) begin
            vectors++;
            if (valid_o !== 1'b1 || pc_o !== next_pc) begin
                miscompares++; $display("[TB] FAIL drain_pc[%0d]: got valid=%b pc=%h, expected valid=1 pc=%h", j, valid_o, pc_o, next_pc);
            end
            vectors++;
            if (inst0_o !== exp_word(next_pc)) begin miscompares++; $display("[TB] FAIL drain_inst0[%0d]: got %h, expected %h", j, inst0_o, exp_word(next_pc)); end
            next_pc = next_pc + 32'd8;
            tick();
        end
    endtask

    task automatic test_redirect();
        ready_i = 1'b0;
        tick();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h104;
        vectors++;
        if (imem_stall_o !== 1'b1) begin miscompares++; $display("[TB] FAIL redir_stall: got %b, expected 1", imem_stall_o); end
        vectors++;
        if (valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL redir_full_valid: got %b, expected 1", valid_o); end
        tick();
        redirect_i = 1'b0;
        ready_i = 1'b1;
        vectors++;
        if (valid_o !== 1'b0 || imem_addr_o !== 10'h104) begin
            miscompares++; $display("[TB] FAIL redir_flush: got valid=%b addr=%h, expected valid=0 addr=104", valid_o, imem_addr_o);
        end
        tick();
        vectors++;
        if (valid_o !== 1'b0 || imem_addr_o !== 10'h10C) begin
            miscompares++; $display("[TB] FAIL redir_gap: got valid=%b addr=%h, expected valid=0 addr=10c", valid_o, imem_addr_o);
        end
        tick();
        next_pc = 32'h104;
        for (int j = 0; j < 2; j++) begin
            vectors++;
            if (valid_o !== 1'b1 || pc_o !== next_pc) begin
                miscompares++; $display("[TB] FAIL redir_pc[%0d]: got valid=%b pc=%h, expected valid=1 pc=%h", j, valid_o, pc_o, next_pc);
            end
            vectors++;
            if (inst0_o !== exp_word(next_pc)) begin miscompares++; $display("[TB] FAIL redir_inst0[%0d]: got %h, expected %h", j, inst0_o, exp_word(next_pc)); end
            next_pc = next_pc + 32'd8;
            tick();
        end
    endtask

    task automatic test_wrap();
        redirect_i = 1'b1;
        redirect_pc_i = 32'h3F8;
        vectors++;
        if (valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_pre_valid: got %b, expected 1", valid_o); end
        tick();
        redirect_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || imem_addr_o !== 10'h3F8) begin
            miscompares++; $display("[TB] FAIL wrap_addr0: got valid=%b addr=%h, expected valid=0 addr=3f8", valid_o, imem_addr_o);
        end
        tick();
        vectors++;
        if (imem_addr_o !== 10'h000) begin miscompares++; $display("[TB] FAIL wrap_addr1: got %h, expected 000", imem_addr_o); end
        tick();
        vectors++;
        if (valid_o !== 1'b1 || pc_o !== 32'h3F8) begin
            miscompares++; $display("[TB] FAIL wrap_pc0: got valid=%b pc=%h, expected valid=1 pc=3f8", valid_o, pc_o);
        end
        vectors++;
        if (inst1_o !== exp_word(32'h3FC)) begin miscompares++; $display("[TB] FAIL wrap_inst1: got %h, expected %h", inst1_o, exp_word(32'h3FC)); end
        vectors++;
        if (imem_addr_o !== 10'h008) begin miscompares++; $display("[TB] FAIL wrap_addr2: got %h, expected 008", imem_addr_o); end
        tick();
        vectors++;
        if (pc_o !== 32'h400) begin miscompares++; $display("[TB] FAIL wrap_pc1: got %h, expected 400", pc_o); end
        vectors++;
        if (inst0_o !== 32'h00100513) begin miscompares++; $display("[TB] FAIL wrap_inst0: got %h, expected 00100513", inst0_o); end
        tick();
    endtask

    task automatic test_async_reset();
        vectors++;
        if (valid_o !== 1'b1) begin miscompares++; $display("[TB] FAIL areset_pre_valid: got %b, expected 1", valid_o); end
        #2;
        reset_i = 1'b1;
        #1;
        vectors++;
        if (valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL areset_valid: got %b, expected 0", valid_o); end
        vectors++;
        if (pc_o !== 32'h0 || inst0_o !== 32'h0) begin
            miscompares++; $display("[TB] FAIL areset_outputs: got pc=%h inst0=%h, expected 0 0", pc_o, inst0_o);
        end
        vectors++;
        if (imem_stall_o !== 1'b1 || imem_addr_o !== 10'h0) begin
            miscompares++; $display("[TB] FAIL areset_mem: got stall=%b addr=%h, expected 1 000", imem_stall_o, imem_addr_o);
        end
        tick();
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (imem_addr_o !== 10'(8 * k)) begin
                miscompares++; $display("[TB] FAIL restart_addr[%0d]: got %h, expected %h", k, imem_addr_o, 10'(8 * k));
            end
            if (k >= 2) begin
                vectors++;
                if (valid_o !== 1'b1 || pc_o !== 32'(8 * (k - 2))) begin
                    miscompares++; $display("[TB] FAIL restart_pc[%0d]: got valid=%b pc=%h, expected valid=1 pc=%h", k, valid_o, pc_o, 32'(8 * (k - 2)));
                end
            end
            tick();
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin
            mem[i] = 8'(i * 37 + 11);
        end
        mem[0] = 8'h13; mem[1] = 8'h05; mem[2] = 8'h10; mem[3] = 8'h00;
        mem[4] = 8'h93; mem[5] = 8'h05; mem[6] = 8'h20; mem[7] = 8'h00;

        test_reset();
        test_startup();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_async_reset();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation still running at time %0t, expected to finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
